// File: rtl/ame_comp_pkg.sv
// Shared types for the ame_num_compare arbiter: candidate vector shape and FSM states.
package ame_comp_pkg;

  localparam int COMP_NUM      = 6;
  localparam int COMP_VEC_BITS = 64;

  typedef logic [COMP_NUM-1:0][COMP_VEC_BITS-1:0] comp_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ame_rr_arbiter.sv
// Combinational round-robin grant: the first valid requester searching upward
// (with wrap) from i_ptr+1, returned both one-hot and as an index.
module ame_rr_arbiter #(
  parameter int REQ_NUM      = 4,
  parameter int REQ_IDX_BITS = 2
) (
  input  logic [REQ_NUM-1:0]      i_valid,
  input  logic [REQ_IDX_BITS-1:0] i_ptr,
  output logic [REQ_NUM-1:0]      o_grant,
  output logic [REQ_IDX_BITS-1:0] o_idx,
  output logic                    o_any
);

  int                      w_sum;
  logic [REQ_IDX_BITS-1:0] w_cand;

  // Offsets 1..REQ_NUM visit every requester once, ending on the previous winner.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    w_cand  = '0;
    for (int i = 1; i <= REQ_NUM; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= REQ_NUM) begin
        w_sum = w_sum - REQ_NUM;
      end
      w_cand = REQ_IDX_BITS'(w_sum);
      if (!o_any && i_valid[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ame_comp_arbiter.sv
// Shares one ame_num_compare among REQ_NUM requesters: round-robin grant, compare
// handshake guarded by a timeout, and a valid/ready response carrying min, index and id.
module ame_comp_arbiter
  import ame_comp_pkg::*;
#(
  parameter int REQ_NUM            = 4,
  parameter int REQ_IDX_BITS       = 2,
  parameter int COMP_DATA_BITS     = 64,
  parameter int COMP_DATA_IDX_BITS = 3,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                                                clk_i,
  input  logic                                                rst_n_i,
  input  logic [REQ_NUM-1:0]                                  req_valid_i,
  output logic [REQ_NUM-1:0]                                  req_ready_o,
  input  logic [REQ_NUM-1:0][COMP_NUM-1:0][COMP_DATA_BITS-1:0] req_data_i,
  output logic                                                rsp_valid_o,
  input  logic                                                rsp_ready_i,
  output logic [REQ_IDX_BITS-1:0]                             rsp_req_idx_o,
  output logic [COMP_DATA_BITS-1:0]                           rsp_data_o,
  output logic [COMP_DATA_IDX_BITS-1:0]                       rsp_data_idx_o,
  output logic                                                rsp_err_o,
  output logic                                                comp_init_o,
  input  logic                                                comp_done_i,
  output logic [COMP_NUM-1:0][COMP_DATA_BITS-1:0]             comp_data_o,
  input  logic [COMP_DATA_BITS-1:0]                           comp_data_i,
  input  logic [COMP_DATA_IDX_BITS-1:0]                       comp_data_idx_i,
  output logic                                                busy_o
);

  localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  arb_state_t                              r_state;
  arb_state_t                              w_next_state;
  logic [REQ_IDX_BITS-1:0]                 r_ptr;
  logic [REQ_IDX_BITS-1:0]                 r_req_idx;
  logic [COMP_NUM-1:0][COMP_DATA_BITS-1:0] r_comp_data;
  logic [COMP_DATA_BITS-1:0]               r_rsp_data;
  logic [COMP_DATA_IDX_BITS-1:0]           r_rsp_idx;
  logic                                    r_err;
  logic [CNT_BITS-1:0]                     r_cnt;

  logic [REQ_NUM-1:0]                      w_grant;
  logic [REQ_IDX_BITS-1:0]                 w_grant_idx;
  logic                                    w_grant_any;
  logic                                    w_accept;
  logic                                    w_done;
  logic                                    w_timeout;

  ame_rr_arbiter #(
    .REQ_NUM      (REQ_NUM),
    .REQ_IDX_BITS (REQ_IDX_BITS)
  ) u_rr_arbiter (
    .i_valid (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A done in the final timeout cycle is checked first, so real data wins the race.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    req_ready_o  = '0;
    comp_init_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    busy_o       = 1'b1;
    case (r_state)
      IDLE: begin
        busy_o      = 1'b0;
        req_ready_o = w_grant;
        if (w_grant_any) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        comp_init_o = 1'b1;
        if (comp_done_i) begin
          w_done       = 1'b1;
          w_next_state = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Pointer starts at the last requester so requester 0 wins the first arbitration.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr       <= REQ_IDX_BITS'(REQ_NUM - 1);
      r_req_idx   <= '0;
      r_comp_data <= '0;
      r_rsp_data  <= '0;
      r_rsp_idx   <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_comp_data <= req_data_i[w_grant_idx];
        r_req_idx   <= w_grant_idx;
        r_ptr       <= w_grant_idx;
        r_cnt       <= '0;
      end else if ((r_state == RUN) && (r_cnt != CNT_LAST)) begin
        r_cnt <= r_cnt + CNT_BITS'(1);
      end
      if (w_done) begin
        r_rsp_data <= comp_data_i;
        r_rsp_idx  <= comp_data_idx_i;
        r_err      <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= '1;
        r_rsp_idx  <= '0;
        r_err      <= 1'b1;
      end
    end
  end

  assign comp_data_o    = r_comp_data;
  assign rsp_req_idx_o  = r_req_idx;
  assign rsp_data_o     = r_rsp_data;
  assign rsp_data_idx_o = r_rsp_idx;
  assign rsp_err_o      = r_err;

endmodule
